dcache_write_buffer: RTL and testbench

Posted-write buffer between the data cache and the AXI bridge's `d_wr_*` port. It accepts dirty-line evictions and uncached word stores from the dcache in a single cycle and queues them in a small FIFO. It drains the queue one request at a time into the bridge, and reports drained status on `write_buffer_empty`. It also flags dcache reads that target a queued or in-flight write, so a read never overtakes a pending store.

---
 rtl/dcache_write_buffer_pkg.sv | 23 ++
 rtl/dcache_write_buffer_fifo.sv | 78 +++++++
 rtl/dcache_write_buffer.sv | 107 ++++++++++
 tb/tb_dcache_write_buffer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_write_buffer_pkg.sv
// Shared types and constants for the dcache posted-write buffer.
package wb_pkg;

   localparam logic [2:0] WB_TYPE_BYTE = 3'b000;
   localparam logic [2:0] WB_TYPE_HALF = 3'b001;
   localparam logic [2:0] WB_TYPE_WORD = 3'b010;
   localparam logic [2:0] WB_TYPE_LINE = 3'b100;

   localparam int unsigned WB_LINE_OFF_W = 4;
   localparam int unsigned WB_LINE_W     = 32 - WB_LINE_OFF_W;

   typedef struct packed {
      logic [2:0]   wtype;
      logic [31:0]  addr;
      logic [3:0]   wstrb;
      logic [127:0] data;
   } wb_entry_t;

   function automatic logic [WB_LINE_W-1:0] wb_line(input logic [31:0] addr);
      return addr[31:WB_LINE_OFF_W];
   endfunction

endpackage

// File: rtl/dcache_write_buffer_fifo.sv
// Entry storage for the write buffer: circular FIFO with head/tail/count,
// per-slot valid bits and the line address of every slot for hazard compares.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              push,
   input  wb_entry_t                         push_entry,
   input  logic                              pop,
   output wb_entry_t                         head_entry,
   output logic                              full,
   output logic                              empty,
   output logic [DEPTH-1:0]                  valid,
   output logic [DEPTH-1:0][WB_LINE_W-1:0]   line_addr
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;
   wb_entry_t        mem [DEPTH];

   // count never exceeds DEPTH, so its MSB alone marks a full buffer
   assign full    = count[PTR_W];
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
      end else begin
         if (do_push) begin
            tail        <= tail + PTR_ONE;
            valid[tail] <= 1'b1;
         end
         if (do_pop) begin
            head        <= head + PTR_ONE;
            valid[head] <= 1'b0;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[tail] <= push_entry;
      end
   end

   assign head_entry = mem[head];

   always_comb begin
      line_addr = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         line_addr[i] = wb_line(mem[i].addr);
      end
   end

   a_count_bound: assert property (@(posedge clock) disable iff (reset)
      count <= (PTR_W + 1)'(DEPTH));

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write buffer between the dcache and the AXI bridge write port.
// Optional WB_ADDR_HAZARD_EN: per-entry line-address read hazard check.
module dcache_write_buffer
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         wr_req,
   input  logic [2:0]   wr_type,
   input  logic [31:0]  wr_addr,
   input  logic [3:0]   wr_wstrb,
   input  logic [127:0] wr_data,
   output logic         wr_rdy,
   input  logic         rd_req,
   input  logic [31:0]  rd_addr,
   output logic         rd_conflict,
   output logic         d_wr_req,
   output logic [2:0]   d_wr_type,
   output logic [31:0]  d_wr_addr,
   output logic [3:0]   d_wr_wstrb,
   output logic [127:0] d_wr_data,
   input  logic         d_wr_rdy,
   output logic         write_buffer_empty
);

   wb_entry_t                       push_entry;
   wb_entry_t                       head_entry;
   logic                            full;
   logic                            empty;
   logic [DEPTH-1:0]                valid;
   logic [DEPTH-1:0][WB_LINE_W-1:0] line_addr;
   logic                            push;
   logic                            pop;
   logic                            inflight;
   logic [31:0]                     inflight_addr;

   assign push_entry = '{wtype: wr_type, addr: wr_addr, wstrb: wr_wstrb, data: wr_data};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .full       (full),
      .empty      (empty),
      .valid      (valid),
      .line_addr  (line_addr)
   );

   assign wr_rdy   = !full;
   assign push     = wr_req && wr_rdy;
   assign d_wr_req = !empty;
   assign pop      = d_wr_req && d_wr_rdy;

   assign d_wr_type  = head_entry.wtype;
   assign d_wr_addr  = head_entry.addr;
   assign d_wr_wstrb = head_entry.wstrb;
   assign d_wr_data  = head_entry.data;

   // Bridge holds d_wr_rdy low until the B response, so a later rdy with no
   // new pop means the previous write has fully completed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         inflight      <= 1'b0;
         inflight_addr <= '0;
      end else if (pop) begin
         inflight      <= 1'b1;
         inflight_addr <= head_entry.addr;
      end else if (d_wr_rdy) begin
         inflight      <= 1'b0;
      end
   end

   assign write_buffer_empty = empty && !inflight;

`ifdef WB_ADDR_HAZARD_EN
   logic hit;
   logic unused_low_bits;

   always_comb begin
      hit = inflight && (wb_line(inflight_addr) == wb_line(rd_addr));
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (valid[i] && (line_addr[i] == wb_line(rd_addr))) begin
            hit = 1'b1;
         end
      end
      rd_conflict = rd_req && hit;
   end

   assign unused_low_bits = ^{rd_addr[WB_LINE_OFF_W-1:0], inflight_addr[WB_LINE_OFF_W-1:0]};
`else
   logic unused_hazard;

   assign rd_conflict   = rd_req && !write_buffer_empty;
   assign unused_hazard = ^{valid, line_addr, inflight_addr, rd_addr};
`endif

   a_head_stable: assert property (@(posedge clock) disable iff (reset)
      (d_wr_req && !d_wr_rdy) |=> (d_wr_req && $stable(d_wr_addr) && $stable(d_wr_data)));

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer with a simple bridge model.
`timescale 1ns/1ps
module tb_dcache_write_buffer;
   import wb_pkg::*;

   localparam int unsigned DEPTH = 4;

   logic         clock;
   logic         reset;
   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         rd_conflict;
   logic         d_wr_req;
   logic [2:0]   d_wr_type;
   logic [31:0]  d_wr_addr;
   logic [3:0]   d_wr_wstrb;
   logic [127:0] d_wr_data;
   logic         d_wr_rdy;
   logic         write_buffer_empty;

   int        checks = 0;
   int        errors = 0;
   wb_entry_t sb[$];
   int        bridge_lat = 5;
   bit        bridge_hold = 0;
   int        busy = 0;

   dcache_write_buffer #(
      .DEPTH (DEPTH)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .wr_req             (wr_req),
      .wr_type            (wr_type),
      .wr_addr            (wr_addr),
      .wr_wstrb           (wr_wstrb),
      .wr_data            (wr_data),
      .wr_rdy             (wr_rdy),
      .rd_req             (rd_req),
      .rd_addr            (rd_addr),
      .rd_conflict        (rd_conflict),
      .d_wr_req           (d_wr_req),
      .d_wr_type          (d_wr_type),
      .d_wr_addr          (d_wr_addr),
      .d_wr_wstrb         (d_wr_wstrb),
      .d_wr_data          (d_wr_data),
      .d_wr_rdy           (d_wr_rdy),
      .write_buffer_empty (write_buffer_empty)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // bridge: accept on rdy, go busy for bridge_lat cycles, compare against scoreboard
   initial begin
      d_wr_rdy = 1'b1;
      forever begin
         bit        acc;
         wb_entry_t e;
         @(negedge clock);
         acc = !reset && d_wr_req && d_wr_rdy;
         if (acc) begin
            if (sb.size() == 0) begin
               check("pop_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               check("pop_type",  d_wr_type,  e.wtype);
               check("pop_addr",  d_wr_addr,  e.addr);
               check("pop_wstrb", d_wr_wstrb, e.wstrb);
               check("pop_data",  d_wr_data,  e.data);
            end
         end
         @(posedge clock);
         #1;
         if (reset)          busy = 0;
         else if (acc)       busy = bridge_lat;
         else if (busy > 0)  busy--;
         d_wr_rdy = (busy == 0) && !bridge_hold;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic push_w(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                         input logic [127:0] d, input bit exp_acc);
      wb_entry_t e;
      wr_req = 1'b1; wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d;
      @(negedge clock);
      check("wr_rdy", wr_rdy, exp_acc);
      if (exp_acc) begin
         e.wtype = t; e.addr = a; e.wstrb = s; e.data = d;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
      wr_req = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      bit ok;
      ok = 0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clock);
         if (sb.size() == 0 && write_buffer_empty) begin
            ok = 1;
            break;
         end
      end
      check("drain_done", ok, 1);
      check("drain_sb_left", sb.size(), 0);
      step(1);
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [2:0] types [4];
      bit         rose;
      types[0] = WB_TYPE_BYTE; types[1] = WB_TYPE_HALF;
      types[2] = WB_TYPE_WORD; types[3] = WB_TYPE_LINE;

      wr_req = 0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
      rd_req = 0; rd_addr = '0;
      reset = 1'b1;
      step(3);
      rd_req = 1'b1; rd_addr = 32'h1000_0040;
      #1;
      check("rst_wr_rdy",   wr_rdy, 1);
      check("rst_d_wr_req", d_wr_req, 0);
      check("rst_conflict", rd_conflict, 0);
      check("rst_empty",    write_buffer_empty, 1);
      reset = 1'b0; rd_req = 1'b0;
      step(2);

      // single line write, bridge idle
      push_w(WB_TYPE_LINE, 32'h1000_0040, 4'hF, rnd128(), 1);
      check("t1_d_wr_req", d_wr_req, 1);
      check("t1_empty_busy", write_buffer_empty, 0);
      rd_req = 1'b1; rd_addr = 32'h1000_004C;
      step(1);
      rose = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (d_wr_rdy) begin
            rose = 1;
            break;
         end
         check("t1_empty_inflight", write_buffer_empty, 0);
         check("t1_conflict_inflight", rd_conflict, 1);
      end
      check("t1_rdy_returns", rose, 1);
      check("t1_empty_at_rdy", write_buffer_empty, 0);
      check("t1_conflict_at_rdy", rd_conflict, 1);
      @(negedge clock);
      check("t1_empty_done", write_buffer_empty, 1);
      check("t1_conflict_done", rd_conflict, 0);
      rd_req = 1'b0;
      step(1);

      // fill with bridge blocked
      bridge_hold = 1;
      step(1);
      push_w(WB_TYPE_LINE, 32'h3000_0000, 4'hF, rnd128(), 1);
      push_w(WB_TYPE_WORD, 32'h2000_0008, 4'hF, {96'b0, $urandom}, 1);
      push_w(WB_TYPE_HALF, 32'h4000_0102, 4'hC, {96'b0, $urandom}, 1);
      push_w(WB_TYPE_BYTE, 32'h5000_0003, 4'h8, {96'b0, $urandom}, 1);
      check("t2_full_wr_rdy", wr_rdy, 0);
      check("t2_full_d_wr_req", d_wr_req, 1);
      push_w(WB_TYPE_WORD, 32'h7000_0000, 4'hF, rnd128(), 0);
      rd_req = 1'b1; rd_addr = 32'h2000_000C;
      #1 check("t4_conflict_same_line", rd_conflict, 1);
      rd_addr = 32'h2000_0010;
`ifdef WB_ADDR_HAZARD_EN
      #1 check("t4_conflict_next_line", rd_conflict, 0);
`else
      #1 check("t4_conflict_next_line", rd_conflict, 1);
`endif
      rd_req = 1'b0;
      #1 check("t4_conflict_no_req", rd_conflict, 0);

      // full buffer: push and pop in the same cycle, push refused
      bridge_hold = 0;
      step(1);
      push_w(WB_TYPE_WORD, 32'h7000_0004, 4'hF, rnd128(), 0);
      bridge_hold = 1;
      push_w(WB_TYPE_LINE, 32'h6000_0000, 4'hF, rnd128(), 1);
      check("t3_refull_wr_rdy", wr_rdy, 0);
      check("t3_refull_d_wr_req", d_wr_req, 1);
      bridge_lat = 2;
      bridge_hold = 0;
      wait_drain(200);

      // streaming pushes against a fast bridge
      bridge_lat = 1;
      for (int i = 0; i < 6; i++) begin
         push_w(types[i % 4], $urandom & 32'hFFFF_FFF0, 4'($urandom), rnd128(), 1);
      end
      wait_drain(200);

      // reset while draining with three entries still queued
      bridge_hold = 1;
      bridge_lat = 3;
      step(1);
      for (int i = 0; i < 4; i++) begin
         push_w(WB_TYPE_LINE, 32'h8000_0000 + 32'(i * 16), 4'hF, rnd128(), 1);
      end
      bridge_hold = 0;
      step(2);
      rd_req = 1'b1; rd_addr = 32'h8000_0010;
      #1 check("t6_pre_conflict", rd_conflict, 1);
      reset = 1'b1;
      #1;
      check("t6_wr_rdy", wr_rdy, 1);
      check("t6_d_wr_req", d_wr_req, 0);
      check("t6_empty", write_buffer_empty, 1);
      check("t6_conflict", rd_conflict, 0);
      sb.delete();
      step(2);
      reset = 1'b0; rd_req = 1'b0;
      step(1);

      push_w(WB_TYPE_WORD, 32'h9000_0004, 4'h3, {96'b0, $urandom}, 1);
      wait_drain(100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
